// File: rtl/hdmi_packet_scheduler_if.sv
// HDMI packet scheduler bus: blanking/request inputs and island timing outputs.
//   I_vsync_start  : pulse at the start of vertical blanking (AVI / audio InfoFrame due)
//   I_island_ok    : enough blanking remains to fit a whole data island
//   I_audio_req    : level, an audio sample packet is available
//   I_acr_tick     : pulse, an ACR packet is due
//   O_period       : 0 control, 1 preamble, 2 guard, 3 data
//   O_pkt_type     : 0 none, 1 audio sample, 2 ACR, 3 AVI InfoFrame, 4 audio InfoFrame
//   O_pkt_idx      : data cycle index within the packet
//   O_pkt_start    : pulse on data cycle 0
//   O_audio_ack    : pulse when an audio sample packet is granted
//   O_acr_overrun  : sticky, an ACR tick arrived while ACR was still pending
// master drives the requests (timing generator side); slave is the scheduler.
interface hdmi_packet_scheduler_if;
  logic       I_vsync_start;
  logic       I_island_ok;
  logic       I_audio_req;
  logic       I_acr_tick;
  logic [1:0] O_period;
  logic [2:0] O_pkt_type;
  logic [4:0] O_pkt_idx;
  logic       O_pkt_start;
  logic       O_audio_ack;
  logic       O_acr_overrun;

  modport master (
    output I_vsync_start, I_island_ok, I_audio_req, I_acr_tick,
    input  O_period, O_pkt_type, O_pkt_idx, O_pkt_start, O_audio_ack, O_acr_overrun
  );

  modport slave (
    input  I_vsync_start, I_island_ok, I_audio_req, I_acr_tick,
    output O_period, O_pkt_type, O_pkt_idx, O_pkt_start, O_audio_ack, O_acr_overrun
  );
endinterface

// File: rtl/hdmi_packet_scheduler.sv
// HDMI data-island packet scheduler.
// Arbitrates pending packet requests (ACR > AVI > audio InfoFrame > audio sample)
// and sequences one packet per island: preamble, leading guard, 32 data cycles,
// trailing guard, then a minimum control gap before the next island.
// Ports:
//   I_clk_pixel : pixel clock
//   I_reset_n   : asynchronous active-low reset
//   bus         : hdmi_packet_scheduler_if.slave (requests in, island timing out)
// Configuration macro: HDMI_AUDIO_INFOFRAME_EN enables the audio InfoFrame
// (type 4) request flag; when undefined the flag does not exist.
module hdmi_packet_scheduler #(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned GUARD_LEN    = 2,
  parameter int unsigned MIN_GAP      = 4
) (
  input  logic                  I_clk_pixel,
  input  logic                  I_reset_n,
  hdmi_packet_scheduler_if.slave bus
);

  localparam int unsigned DATA_LEN = 32;
  localparam int unsigned MAX_A    = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
  localparam int unsigned MAX_B    = (MIN_GAP > DATA_LEN) ? MIN_GAP : DATA_LEN;
  localparam int unsigned MAX_LEN  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W    = $clog2(MAX_LEN);
  localparam int unsigned IDX_W    = 5;

  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(MIN_GAP - 1);

  localparam logic [1:0] PER_CTRL  = 2'd0;
  localparam logic [1:0] PER_PRE   = 2'd1;
  localparam logic [1:0] PER_GUARD = 2'd2;
  localparam logic [1:0] PER_DATA  = 2'd3;

  localparam logic [2:0] PKT_NONE  = 3'd0;
  localparam logic [2:0] PKT_AUDIO = 3'd1;
  localparam logic [2:0] PKT_ACR   = 3'd2;
  localparam logic [2:0] PKT_AVI   = 3'd3;
  localparam logic [2:0] PKT_AIF   = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    LEAD_GUARD,
    DATA,
    TRAIL_GUARD,
    GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               acr_pend;
  logic               avi_pend;
`ifdef HDMI_AUDIO_INFOFRAME_EN
  logic               aif_pend;
`endif

  logic               arb_slot;
  logic               grant;
  logic [2:0]         gnt_type;

  logic [1:0]         period_q, period_d;
  logic [2:0]         pkt_type_q, pkt_type_d;
  logic [IDX_W-1:0]   pkt_idx_q, pkt_idx_d;
  logic               pkt_start_q, pkt_start_d;
  logic               audio_ack_q, audio_ack_d;
  logic               acr_overrun_q;

  // Request arbitration. The final gap cycle doubles as an arbitration slot so
  // back-to-back islands are separated by exactly MIN_GAP control cycles.
  always_comb begin
    gnt_type = PKT_NONE;
    if (acr_pend) begin
      gnt_type = PKT_ACR;
    end else if (avi_pend) begin
      gnt_type = PKT_AVI;
`ifdef HDMI_AUDIO_INFOFRAME_EN
    end else if (aif_pend) begin
      gnt_type = PKT_AIF;
`endif
    end else if (bus.I_audio_req) begin
      gnt_type = PKT_AUDIO;
    end
    arb_slot = (state_q == IDLE) || ((state_q == GAP) && (cnt_q == GAP_LAST));
    grant    = arb_slot && bus.I_island_ok && (gnt_type != PKT_NONE);
  end

  // State register.
  always_ff @(posedge I_clk_pixel or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt counts cycles spent in the current state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant) state_d = PREAMBLE;
      end
      PREAMBLE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = LEAD_GUARD;
          cnt_d   = '0;
        end
      end
      LEAD_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = TRAIL_GUARD;
          cnt_d   = '0;
        end
      end
      TRAIL_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = grant ? PREAMBLE : IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    period_d    = PER_CTRL;
    pkt_type_d  = PKT_NONE;
    pkt_idx_d   = '0;
    pkt_start_d = 1'b0;
    audio_ack_d = 1'b0;
    case (state_d)
      PREAMBLE:    period_d = PER_PRE;
      LEAD_GUARD:  period_d = PER_GUARD;
      TRAIL_GUARD: period_d = PER_GUARD;
      DATA: begin
        period_d    = PER_DATA;
        pkt_idx_d   = IDX_W'(cnt_d);
        pkt_start_d = (cnt_d == '0);
      end
      default: ;
    endcase
    if (grant) begin
      pkt_type_d  = gnt_type;
      audio_ack_d = (gnt_type == PKT_AUDIO);
    end else if (state_d != IDLE && state_d != GAP) begin
      pkt_type_d  = pkt_type_q;
    end
  end

  // Output registers.
  always_ff @(posedge I_clk_pixel or negedge I_reset_n) begin
    if (!I_reset_n) begin
      period_q    <= PER_CTRL;
      pkt_type_q  <= PKT_NONE;
      pkt_idx_q   <= '0;
      pkt_start_q <= 1'b0;
      audio_ack_q <= 1'b0;
    end else begin
      period_q    <= period_d;
      pkt_type_q  <= pkt_type_d;
      pkt_idx_q   <= pkt_idx_d;
      pkt_start_q <= pkt_start_d;
      audio_ack_q <= audio_ack_d;
    end
  end

  // Pending flags: a set event in the grant cycle wins over the grant's clear.
  always_ff @(posedge I_clk_pixel or negedge I_reset_n) begin
    if (!I_reset_n) begin
      acr_pend      <= 1'b0;
      avi_pend      <= 1'b0;
`ifdef HDMI_AUDIO_INFOFRAME_EN
      aif_pend      <= 1'b0;
`endif
      acr_overrun_q <= 1'b0;
    end else begin
      acr_pend <= (acr_pend && !(grant && gnt_type == PKT_ACR)) || bus.I_acr_tick;
      avi_pend <= (avi_pend && !(grant && gnt_type == PKT_AVI)) || bus.I_vsync_start;
`ifdef HDMI_AUDIO_INFOFRAME_EN
      aif_pend <= (aif_pend && !(grant && gnt_type == PKT_AIF)) || bus.I_vsync_start;
`endif
      // A tick that lands on the ACR grant re-arms the flag rather than overrunning.
      if (bus.I_acr_tick && acr_pend && !(grant && gnt_type == PKT_ACR))
        acr_overrun_q <= 1'b1;
    end
  end

  assign bus.O_period      = period_q;
  assign bus.O_pkt_type    = pkt_type_q;
  assign bus.O_pkt_idx     = pkt_idx_q;
  assign bus.O_pkt_start   = pkt_start_q;
  assign bus.O_audio_ack   = audio_ack_q;
  assign bus.O_acr_overrun = acr_overrun_q;

endmodule

// File: doc/hdmi_packet_scheduler.md
HDMI_PACKET_SCHEDULER -- requirements
Module: hdmi_packet_scheduler

Interface
REQ-001 SHALL have parameter PREAMBLE_LEN, default 8, meaning control-period preamble cycles before each data island.
REQ-002 SHALL have parameter GUARD_LEN, default 2, meaning guard-band cycles at the start and at the end of each island.
REQ-003 SHALL have parameter MIN_GAP, default 4, meaning the minimum number of control cycles between two islands.
REQ-004 SHALL have port I_clk_pixel, input, 1 bit: pixel clock, the only clock.
REQ-005 SHALL have port I_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port I_vsync_start, input, 1 bit: one-cycle pulse at the start of each frame's vertical blanking.
REQ-007 SHALL have port I_island_ok, input, 1 bit: high while at least PREAMBLE_LEN+2*GUARD_LEN+32 blanking cycles remain.
REQ-008 SHALL have port I_audio_req, input, 1 bit: level, an audio sample packet is available.
REQ-009 SHALL have port I_acr_tick, input, 1 bit: one-cycle pulse, an ACR packet is due.
REQ-010 SHALL have port O_period, output, 2 bits: 0 control, 1 preamble, 2 guard, 3 data.
REQ-011 SHALL have port O_pkt_type, output, 3 bits: 0 none, 1 audio sample, 2 ACR, 3 AVI InfoFrame, 4 audio InfoFrame.
REQ-012 SHALL have port O_pkt_idx, output, 5 bits: data cycle index 0..31 within the packet.
REQ-013 SHALL have port O_pkt_start, output, 1 bit: pulse on data cycle 0.
REQ-014 SHALL have port O_audio_ack, output, 1 bit: one-cycle pulse when an audio sample packet is granted.
REQ-015 SHALL have port O_acr_overrun, output, 1 bit: sticky, set when an ACR tick arrives while ACR is already pending.

Function
REQ-016 SHALL implement an FSM with states IDLE, PREAMBLE, LEAD_GUARD, DATA, TRAIL_GUARD, GAP; all outputs SHALL be registered.
REQ-017 SHALL keep pending flags: acr_pend, set by I_acr_tick; avi_pend, set by I_vsync_start; aif_pend, set by I_vsync_start (REQ-030).
REQ-018 SHALL grant in IDLE when I_island_ok=1 and any request is pending, using fixed priority ACR > AVI > audio InfoFrame > audio sample.
REQ-019 On grant SHALL latch O_pkt_type, clear the granted pending flag, pulse O_audio_ack if the grant is audio, and enter PREAMBLE; O_period=1 SHALL appear the cycle after grant.
REQ-020 PREAMBLE SHALL last PREAMBLE_LEN cycles, LEAD_GUARD GUARD_LEN cycles (O_period=2), DATA 32 cycles (O_period=3, O_pkt_idx 0..31), TRAIL_GUARD GUARD_LEN cycles (O_period=2), then GAP MIN_GAP cycles (O_period=0), then IDLE.
REQ-021 Each island SHALL carry exactly one packet; O_pkt_type SHALL hold from PREAMBLE through TRAIL_GUARD and return to 0 in GAP/IDLE.
REQ-022 Once started, an island SHALL run to completion regardless of I_island_ok.
REQ-023 A set event coincident with the clear of the same flag at grant SHALL win, so the flag stays 1.
REQ-024 I_acr_tick while acr_pend=1 SHALL set O_acr_overrun and SHALL NOT queue a second ACR; I_vsync_start while avi_pend=1 SHALL leave one AVI pending.
REQ-025 Audio SHALL be granted only while I_audio_req=1 at grant time; no pending request leaves the FSM in IDLE with O_period=0.
REQ-026 O_pkt_idx SHALL be 0 outside DATA; counters SHALL wrap only by state exit, never past 31.

Reset
REQ-027 I_reset_n=0 SHALL asynchronously force IDLE, with all outputs and pending flags at 0 and O_acr_overrun cleared.
REQ-028 Reset mid-island SHALL abort immediately; after release the FSM SHALL restart from IDLE without a partial island.
REQ-029 O_acr_overrun SHALL clear only on reset.

Configuration
REQ-030 Macro HDMI_AUDIO_INFOFRAME_EN defined: aif_pend SHALL exist and type 4 SHALL be schedulable; undefined: aif_pend SHALL be absent, type 4 SHALL never be emitted, and the priority SHALL be ACR > AVI > audio.

Verification
REQ-031 Reset release, I_island_ok=1, I_audio_req=1 -> O_audio_ack at grant; O_period 1x8, 2x2, 3x32, 2x2, 0x4; O_pkt_type=1; O_pkt_start on the first data cycle.
REQ-032 I_vsync_start, I_acr_tick and I_audio_req all pending, I_island_ok=1 (macro defined) -> consecutive island types 2, 3, 4, 1, each separated by 4 control cycles.
REQ-033 Two I_acr_tick pulses before any grant -> exactly one ACR island and O_acr_overrun=1.
REQ-034 I_acr_tick coincident with the ACR grant cycle -> a second ACR island follows; O_acr_overrun stays 0.
REQ-035 Reset asserted at O_pkt_idx=10 -> all outputs 0 immediately; after release with no requests pending -> O_period stays 0.
REQ-036 Macro undefined with I_vsync_start -> only a type 3 island, never type 4.
